// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction_mem word address and holds
// the IF/ID register presented to decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic        redirect_jump,
  input  logic [31:0] redirect_base_pc,
  input  logic [25:0] redirect_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  // state  | meaning
  // WARMUP | single idle cycle after reset release
  // RUN    | normal fetch, redirect and back-pressure handling
  // HALT   | SYSCALL fetched; drain the presented word, then idle until reset
  // FAULT  | fetch attempted out of range; idle until reset
  localparam logic [1:0] WARMUP = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALT   = 2'd2;
  localparam logic [1:0] FAULT  = 2'd3;

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * 4);
  localparam logic [31:0] SYSCALL  = 32'h0000_000C;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] seq_base;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;
  logic        fire;
  logic        transfer;
  logic        out_of_range;

  assign imem_addr = {2'b00, pc[31:2]};
  assign pc_plus4  = pc + 32'd4;

  // Both redirect flavours are relative to the instruction after the branch/jump.
  assign seq_base        = redirect_base_pc + 32'd4;
  assign branch_target   = seq_base + {{14{redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
  assign jump_target     = {seq_base[31:28], redirect_imm, 2'b00};
  assign redirect_target = redirect_jump ? jump_target : branch_target;

  assign transfer     = out_valid && out_ready;
  assign fire         = !stall && (!out_valid || out_ready);
  assign out_of_range = pc >= PC_LIMIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WARMUP;
      pc           <= PC_RESET;
      out_valid    <= 1'b0;
      out_instr    <= 32'd0;
      out_pc       <= 32'd0;
      out_pc_plus4 <= 32'd0;
      halted       <= 1'b0;
      fault        <= 1'b0;
      fetch_count  <= 32'd0;
    end else begin
      case (state)
        WARMUP: state <= RUN;
        RUN: begin
          if (redirect_valid) begin
            pc        <= redirect_target;
            out_valid <= 1'b0;
          end else if (fire) begin
            if (out_of_range) begin
              state     <= FAULT;
              fault     <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              out_instr    <= imem_instr;
              out_pc       <= pc;
              out_pc_plus4 <= pc_plus4;
              out_valid    <= 1'b1;
              pc           <= pc_plus4;
              fetch_count  <= fetch_count + 32'd1;
              if (imem_instr == SYSCALL) begin
                state  <= HALT;
                halted <= 1'b1;
              end
            end
          end else if (transfer) begin
            out_valid <= 1'b0;
          end
        end
        HALT: begin
          if (transfer) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of instruction_mem and downstream of the PC redirect logic.
- Holds the program counter and drives instruction_mem's word address.
- Captures the returned instruction into an IF/ID register and presents it to decode over a valid/ready handshake.
- Handles branch/jump redirects, decode back-pressure, stall, halt on SYSCALL and out-of-range faults.

Parameters:
- PC_RESET, 32'h0000_0000: byte address loaded into PC on reset; must be word aligned.
- IMEM_DEPTH, 128: number of instruction words; legal PC range is 0 to IMEM_DEPTH*4-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_addr  out  32  word index to instruction_mem; combinational, equals {2'b00, pc[31:2]}
- imem_instr  in  32  instruction returned combinationally by instruction_mem
- stall  in  1  suppresses new fetches; does not flush
- redirect_valid  in  1  decode requests a PC change this cycle
- redirect_jump  in  1  1 = J-type target, 0 = PC-relative branch
- redirect_base_pc  in  32  byte PC of the branch/jump instruction
- redirect_imm  in  26  jump: target[25:0]; branch: imm in [15:0], [25:16] ignored
- out_valid  out  1  IF/ID register holds a valid instruction
- out_ready  in  1  decode accepts the current instruction
- out_instr  out  32  fetched instruction
- out_pc  out  32  byte PC of out_instr
- out_pc_plus4  out  32  out_pc + 4, mod 2^32
- halted  out  1  SYSCALL (32'h0000_000C) has been fetched
- fault  out  1  fetch attempted at PC >= IMEM_DEPTH*4
- fetch_count  out  32  number of fetches fired, wraps modulo 2^32

Behaviour:
Reset (async, rst_n=0):
- pc=PC_RESET, state=WARMUP.
- out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, halted=0, fault=0, fetch_count=0.
- Reset asserted mid-operation discards all state immediately.

States: WARMUP, RUN, HALT, FAULT.

WARMUP:
- Lasts exactly one cycle after reset release, then moves to RUN.
- No fetch; redirects ignored.

RUN, evaluated on each rising edge in this priority order:
1. redirect_valid=1:
   - pc <= target, out_valid <= 0 (flush, even if out_valid=1 and out_ready=0), no fetch this cycle.
   - Branch target = redirect_base_pc + 4 + (sign_extend(redirect_imm[15:0]) << 2), mod 2^32.
   - Jump target = {(redirect_base_pc+4)[31:28], redirect_imm, 2'b00}.
2. Else fire = !stall && (!out_valid || out_ready):
   - If pc >= IMEM_DEPTH*4: go to FAULT, fault <= 1, out_valid <= 0, pc unchanged, no count.
   - Otherwise:
     - out_instr <= imem_instr, out_pc <= pc, out_pc_plus4 <= pc+4, out_valid <= 1.
     - pc <= pc+4, fetch_count <= fetch_count+1.
     - If imem_instr == 32'h0000_000C: go to HALT, halted <= 1; pc still advances by 4.
3. Else if out_valid && out_ready (stall=1): out_valid <= 0.
4. Else: hold all state.

Handshake:
- A transfer occurs on any edge with out_valid && out_ready.
- While out_valid=1 and out_ready=0, out_instr, out_pc and out_pc_plus4 stay stable.
- Throughput is one instruction per cycle with out_ready=1 and stall=0.
- Latency from PC update to out_valid is one cycle.

HALT:
- No further fetches; stall and redirects are ignored.
- The SYSCALL word stays presented until accepted, then out_valid <= 0.
- halted stays 1 until reset.

FAULT:
- out_valid=0, fault=1; all inputs ignored until reset.

imem_addr:
- Always reflects the current pc, including in HALT and FAULT.
- It is never gated.

Test Plan:
- Reset release with PC_RESET=0, imem words 0..3 = 0x20080001..0x20080004, out_ready=1: out_valid rises 2 cycles after release; out_pc sequence 0,4,8,12; fetch_count=4 after 4 fires.
- Back-pressure: out_ready=0 for 3 cycles while out_valid=1 with out_pc=8: outputs are frozen, imem_addr stays 3, fetch_count unchanged; on out_ready=1, 12 follows 8 with no duplicate and no skip.
- Branch redirect with base_pc=0x10, imm=16'hFFFC, with out_ready=0 and out_valid=1: out_valid drops next edge; next fetched out_pc=0x04 (0x14-16).
- Jump redirect with base_pc=0x4000_0010, imm=26'h0000020: next out_pc=0x4000_0080 with PC_RESET offset legal range adjusted (IMEM_DEPTH large); with default depth the same jump raises fault=1 one fetch attempt later, out_valid=0.
- Word 5 = 32'h0000_000C: halted=1 when out_pc=0x14 is presented; no further out_valid after it is accepted; a redirect issued in HALT has no effect.
- Stall asserted with out_valid=1 and out_ready=1: out_valid drops, pc held; after stall is released, fetching resumes at the held pc; rst_n pulsed low mid-run clears all outputs asynchronously.
